// File: rtl/pio_pkg.sv
// Shared definitions for the edge-capturing input PIO: bus widths,
// register word addresses and the debounce counter width helper.
package pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RISE   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CAPT   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_FALL   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PARAMS = 3'd5;

  // Counter must hold 0..cycles-1 with one bit of headroom
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
interface pio_in_edge_irq_if;
  import pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by the filtered-value flop.
// Build option PIO_IN_EDGE_IRQ_DEBOUNCE_EN inserts a stability counter so a
// new level must persist DEBOUNCE_CYCLES clocks before it reaches o_filt.
module pio_debounce_bit
  import pio_pkg::*;
`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  output logic o_filt
);

  logic r_s1;
  logic r_s2;
  logic r_filt;

  // Metastability synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count consecutive disagreeing samples; adopt the new level once stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_s2 == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_filt <= r_s2;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end
`else
  // No filtering: filtered value simply follows the synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b0;
    end else begin
      r_filt <= r_s2;
    end
  end
`endif

  assign o_filt = r_filt;

endmodule

// File: rtl/pio_in_edge_irq.sv
// Parametrised Avalon-MM input PIO with per-bit rise/fall edge capture,
// write-1-to-clear capture register, IRQ mask and one level interrupt.
// Build option PIO_IN_EDGE_IRQ_DEBOUNCE_EN enables the per-bit debounce filter
// and reports DEBOUNCE_CYCLES in PARAMS[31:16].
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RISE_EN_RESET   = '1,
  parameter logic [WIDTH-1:0] FALL_EN_RESET   = '0
)(
  input  logic                clk,
  input  logic                reset_n,
  pio_in_edge_irq_if.slave    avs,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
  localparam logic DB_ON = 1'b1;
`else
  localparam logic DB_ON = 1'b0;
`endif
  localparam logic [15:0]       DB_FIELD    = 16'(DEBOUNCE_CYCLES) & {16{DB_ON}};
  localparam logic [DATA_W-1:0] PARAMS_WORD = {DB_FIELD, 10'd0, 6'(WIDTH)};

  logic [WIDTH-1:0]  w_filt;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_evt;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_wr;
  logic              w_unused_wdata;
  logic [DATA_W-1:0] w_rdata;

  logic [WIDTH-1:0]  r_filt_d;
  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_fall_en;
  logic [WIDTH-1:0]  r_mask;
  logic [WIDTH-1:0]  r_capt;
  logic [DATA_W-1:0] r_rdata;

  // Per-bit synchroniser and optional debounce
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce_bit
`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_in    (in_port[gi]),
      .o_filt  (w_filt[gi])
    );
  end

  assign w_wr           = avs.chipselect & ~avs.write_n;
  assign w_wdata        = avs.writedata[WIDTH-1:0];
  assign w_unused_wdata = &{1'b0, avs.writedata};

  assign w_rise = w_filt & ~r_filt_d;
  assign w_fall = ~w_filt & r_filt_d;
  assign w_evt  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr  = (w_wr && (avs.address == ADDR_CAPT)) ? w_wdata : '0;

  // Previous filtered value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_d <= '0;
    end else begin
      r_filt_d <= w_filt;
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise_en <= RISE_EN_RESET;
      r_fall_en <= FALL_EN_RESET;
      r_mask    <= '0;
    end else if (w_wr) begin
      case (avs.address)
        ADDR_RISE: r_rise_en <= w_wdata;
        ADDR_MASK: r_mask    <= w_wdata;
        ADDR_FALL: r_fall_en <= w_wdata;
        default:   ;
      endcase
    end
  end

  // Edge capture: W1C clear, but a same-cycle event keeps the bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capt <= '0;
    end else begin
      r_capt <= (r_capt & ~w_clr) | w_evt;
    end
  end

  // Read mux, decoded from address alone
  always_comb begin
    w_rdata = '0;
    case (avs.address)
      ADDR_DATA:   w_rdata = DATA_W'(w_filt);
      ADDR_RISE:   w_rdata = DATA_W'(r_rise_en);
      ADDR_MASK:   w_rdata = DATA_W'(r_mask);
      ADDR_CAPT:   w_rdata = DATA_W'(r_capt);
      ADDR_FALL:   w_rdata = DATA_W'(r_fall_en);
      ADDR_PARAMS: w_rdata = PARAMS_WORD;
      default:     w_rdata = '0;
    endcase
  end

  // Registered read data, updated every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign avs.readdata = r_rdata;
  assign irq          = |(r_capt & r_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq: directed scenarios with fixed
// expectations plus a randomized phase compared against a behavioural model.
module tb_pio_in_edge_irq;

  localparam int unsigned W  = 8;
  localparam int unsigned DB = 4;
`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
  localparam logic [15:0] DB_FIELD = 16'(DB);
  localparam int unsigned LAT      = 3 + DB;
`else
  localparam logic [15:0] DB_FIELD = 16'd0;
  localparam int unsigned LAT      = 4;
`endif
  localparam int unsigned HOLD = LAT + 3;
  localparam logic [31:0] PARAMS_EXP = {DB_FIELD, 10'd0, 6'(W)};

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic         irq;

  pio_in_edge_irq_if bus();

  pio_in_edge_irq #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .RISE_EN_RESET   ('1),
    .FALL_EN_RESET   ('0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model state
  logic [W-1:0] m_rise, m_fall, m_mask, m_capt;
  logic [31:0]  m_rd;
  logic [W-1:0] in_q[$];   // raw samples taken at the last two edges
  logic [W-1:0] flt_q[$];  // filtered value after the last two edges
  int unsigned  m_run[W];  // consecutive samples disagreeing with filtered value

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic [W-1:0] f);
    case (a)
      3'd0:    return 32'(f);
      3'd1:    return 32'(m_rise);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_capt);
      3'd4:    return 32'(m_fall);
      3'd5:    return PARAMS_EXP;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_rise = '1;
    m_fall = '0;
    m_mask = '0;
    m_capt = '0;
    m_rd   = '0;
    in_q   = '{W'(0), W'(0)};
    flt_q  = '{W'(0), W'(0)};
    for (int i = 0; i < int'(W); i++) m_run[i] = 0;
  endtask

  // One clock edge of the model: raw input reaches the filter two edges later,
  // edges are judged between consecutive filtered values.
  task automatic model_edge(input logic [W-1:0] pin, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [31:0] wd);
    logic [W-1:0] s2, f_old, f_cur, f_new, evt, clr;
    s2    = in_q[0];
    f_old = flt_q[0];
    f_cur = flt_q[1];
    evt   = (f_cur & ~f_old & m_rise) | (~f_cur & f_old & m_fall);
`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
    f_new = f_cur;
    for (int i = 0; i < int'(W); i++) begin
      if (s2[i] != f_cur[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          f_new[i] = s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`else
    f_new = s2;
`endif
    m_rd = model_read(a, f_cur);
    clr  = '0;
    if (cs && !wn) begin
      case (a)
        3'd1:    m_rise = wd[W-1:0];
        3'd2:    m_mask = wd[W-1:0];
        3'd3:    clr    = wd[W-1:0];
        3'd4:    m_fall = wd[W-1:0];
        default: ;
      endcase
    end
    m_capt = (m_capt & ~clr) | evt;
    in_q.push_back(pin);
    void'(in_q.pop_front());
    flt_q.push_back(f_new);
    void'(flt_q.pop_front());
  endtask

  // Advance one clock (called at a negedge), update model, compare outputs
  task automatic step();
    logic [W-1:0] pin;
    logic         cs, wn;
    logic [2:0]   a;
    logic [31:0]  wd;
    pin = in_port;
    cs  = bus.chipselect;
    wn  = bus.write_n;
    a   = bus.address;
    wd  = bus.writedata;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge(pin, cs, wn, a, wd);
    @(negedge clk);
    check("rdata", bus.readdata, m_rd);
    check("irq", 32'(irq), 32'(|(m_capt & m_mask)));
  endtask

  task automatic steps(input int unsigned n);
    for (int i = 0; i < int'(n); i++) step();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    step();
    d = bus.readdata;
  endtask

  logic [31:0] rd;
  logic [31:0] exp_map [8];

  initial begin
    reset_n        = 1'b0;
    in_port        = '0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    model_reset();
    @(negedge clk);
    steps(3);
    reset_n = 1'b1;

    // Reset values of the whole register map
    exp_map = '{32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, PARAMS_EXP, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      bus_read(3'(i), rd);
      check($sformatf("reset_addr%0d", i), rd, exp_map[i]);
      check("reset_irq", 32'(irq), 32'd0);
    end

    // Rising edge on bit 0 with mask set: capture and irq at the expected edge
    bus_write(3'd2, 32'h01);
    in_port = 8'h01;
    steps(LAT - 1);
    check("irq_before_lat", 32'(irq), 32'd0);
    step();
    check("irq_at_lat", 32'(irq), 32'd1);
    bus_read(3'd3, rd); check("capt_rise0", rd, 32'h01);
    bus_read(3'd0, rd); check("data_bit0", rd, 32'h01);

    // Falling-edge only on bit 1, then W1C clear
    bus_write(3'd4, 32'h02);
    bus_write(3'd1, 32'h00);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h03);
    in_port = 8'h03; steps(HOLD);
    in_port = 8'h01; steps(HOLD);
    bus_read(3'd3, rd); check("capt_fall1", rd, 32'h02);
    check("irq_fall1", 32'(irq), 32'd1);
    bus_write(3'd3, 32'h02);
    check("irq_after_clr", 32'(irq), 32'd0);
    bus_read(3'd3, rd); check("capt_cleared", rd, 32'h00);

    // Set wins over simultaneous clear
    bus_write(3'd1, 32'h05);
    bus_write(3'd4, 32'h00);
    in_port = 8'h00; steps(HOLD);
    in_port = 8'h05; steps(HOLD);
    bus_read(3'd3, rd); check("capt_05", rd, 32'h05);
    in_port = 8'h04; steps(HOLD);
    in_port = 8'h05;
    steps(LAT - 1);
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, rd); check("capt_set_wins", rd, 32'h05);
    bus_write(3'd3, 32'h04);
    bus_read(3'd3, rd); check("capt_clr_bit2", rd, 32'h01);

`ifdef PIO_IN_EDGE_IRQ_DEBOUNCE_EN
    // Short pulse filtered out; stable level passes after 3+DB edges
    in_port = 8'h01; steps(HOLD);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h04);
    in_port = 8'h05; steps(3);
    in_port = 8'h01; steps(HOLD);
    bus_read(3'd3, rd); check("db_pulse_capt", rd, 32'h00);
    bus_read(3'd0, rd); check("db_pulse_data", rd, 32'h01);
    in_port = 8'h05;
    steps(6);
    check("db_irq_edge6", 32'(irq), 32'd0);
    step();
    check("db_irq_edge7", 32'(irq), 32'd1);
    bus_read(3'd5, rd); check("db_params_hi", 32'(rd[31:16]), 32'd4);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      case ($urandom_range(0, 7))
        0, 1: bus_write(3'($urandom_range(1, 4)), $urandom);
        2: begin
          bus.address    = 3'($urandom_range(0, 7));
          bus.writedata  = $urandom;
          bus.chipselect = 1'b0;
          bus.write_n    = 1'b0;
          step();
          bus.write_n    = 1'b1;
        end
        default: begin
          bus.address = 3'($urandom_range(0, 7));
          step();
        end
      endcase
    end

    // Asynchronous reset clears captures and irq without a clock edge
    bus_write(3'd1, 32'h01);
    bus_write(3'd4, 32'h00);
    bus_write(3'd2, 32'h00);
    in_port = 8'h00; steps(HOLD);
    bus_write(3'd3, 32'hFF);
    in_port = 8'h01; steps(HOLD);
    bus_write(3'd2, 32'h01);
    check("irq_pre_reset", 32'(irq), 32'd1);
    in_port = 8'h00;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("irq_async_reset", 32'(irq), 32'd0);
    check("rdata_async_reset", bus.readdata, 32'd0);
    @(negedge clk);
    steps(2);
    reset_n = 1'b1;
    steps(HOLD);
    bus_read(3'd3, rd); check("capt_after_reset", rd, 32'h00);
    bus_read(3'd1, rd); check("rise_after_reset", rd, 32'hFF);
    check("irq_after_reset", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM input PIO for buttons and switches; successor to the single-bit button PIO.
- WIDTH input bits; 2-flop synchroniser per bit.
- Per-bit rising- and falling-edge enables; per-bit edge capture with write-1-to-clear; per-bit IRQ mask; one level IRQ to the CPU interrupt controller.
- Optional per-bit debounce filter.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE_CYCLES, 4, stable cycles required before filtered value changes (>=1; used only with debounce feature).
- RISE_EN_RESET, all-ones, reset value of rise-enable register.
- FALL_EN_RESET, 0, reset value of fall-enable register.

Ports:
- clk  in  1  single system clock; all flops rising-edge.
- reset_n  in  1  asynchronous active-low reset, clears all state immediately.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt.

Behaviour:
- Register map (bits above WIDTH-1 read 0, writes ignored):
  - 0 DATA (RO, filtered value).
  - 1 RISE_EN (RW).
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAPTURE (read; write-1-to-clear per bit).
  - 4 FALL_EN (RW).
  - 5 PARAMS (RO): [5:0]=WIDTH, [31:16]=DEBOUNCE_CYCLES if debounce compiled in, else 0.
  - 6-7 read 0.
- Read latency: readdata registered every cycle from address, independent of chipselect; valid 1 clk after address is presented. Reset value 0.
- Writes occur on a clk edge with chipselect=1 and write_n=0.
- Pipeline per bit:
  - s1 <= in_port.
  - s2 <= s1.
  - filt <= s2 (no debounce).
  - filt_d <= filt.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - evt = (rise & RISE_EN) | (fall & FALL_EN).
- Reset: s1, s2, filt, filt_d = 0; IRQ_MASK = 0; EDGE_CAPTURE = 0; RISE_EN / FALL_EN = reset parameters; irq = 0.
- EDGE_CAPTURE[i]:
  - Set on evt[i].
  - Cleared by a write to address 3 with writedata[i]=1.
  - Simultaneous set and clear on the same bit: set wins.
  - Other bits are unaffected by the write.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers; no glitch from address decode.
- Latency, no debounce: in_port change before edge 1 gives EDGE_CAPTURE set after edge 4.
- Pulses shorter than 1 clk may be missed; no requirement to capture them.
- Enabling RISE_EN/FALL_EN or IRQ_MASK does not retroactively capture edges.
- Unmasking an already-set capture bit asserts irq the next cycle.
- Reset asserted mid-operation clears captures and deasserts irq asynchronously. After release, filt starts at 0, so an input held high produces one rising event ~3 clk after release; this is intended (first sample).

Optional Feature:
- Macro: PIO_IN_EDGE_IRQ_DEBOUNCE_EN.
- Defined: per-bit counter cnt[i], width $clog2(DEBOUNCE_CYCLES)+1, reset 0.
  - If s2==filt, cnt <= 0.
  - Else if cnt==DEBOUNCE_CYCLES-1, filt <= s2 and cnt <= 0.
  - Else cnt++.
  - A change must be stable DEBOUNCE_CYCLES clk to propagate.
  - Latency: change before edge 1 gives capture after edge 3+DEBOUNCE_CYCLES.
- Undefined: no counters; filt <= s2 directly; PARAMS[31:16] = 0.

Decomposition:
- Shared package pio_pkg:
  - Register address localparams ADDR_DATA=0, ADDR_RISE=1, ADDR_MASK=2, ADDR_CAPT=3, ADDR_FALL=4, ADDR_PARAMS=5.
  - Helper for count width.
- One natural sub-module, pio_debounce_bit: synchroniser plus optional counter, outputs filt. Instantiated WIDTH times in a generate loop.
- Top level holds registers, capture, read mux and irq.

Test Plan:
- Reset, then read every address -> DATA=0, RISE_EN=0xFF, IRQ_MASK=0, EDGE_CAPTURE=0, FALL_EN=0, PARAMS[5:0]=8; irq=0 throughout.
- IRQ_MASK=0x01, drive in_port[0] 0->1 (no debounce) -> EDGE_CAPTURE=0x01 and irq=1 exactly after 4th clk edge; DATA reads 0x01.
- FALL_EN=0x02, RISE_EN=0; toggle bit1 0->1->0 -> only the fall captured (0x02). Write 0x02 to addr 3 -> capture 0x00 and irq=0 next cycle.
- Capture=0x05; write 0x01 to addr 3 on the same edge a new bit0 event occurs -> capture stays 0x05. Write 0x04 -> 0x01.
- With PIO_IN_EDGE_IRQ_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: 3-clk pulse on bit2 -> no capture, DATA unchanged. 4-clk-stable level -> capture after edge 7; PARAMS[31:16]=4.
- Capture=0x01, mask=0x01; assert reset_n=0 mid-cycle -> irq drops with no clock edge. After release, in_port held 0x00 -> capture stays 0.
